// File: rtl/cpu_io_pkg.sv
// Shared definitions for memory-mapped cpu I/O blocks: register offsets,
// timer CTRL bit positions and the timer's default base address.
package cpu_io_pkg;

  localparam logic [15:0] TIMER_BASE_ADDR = 16'hFF00;

  localparam logic [15:0] OFF_CTRL  = 16'd0;
  localparam logic [15:0] OFF_LOAD  = 16'd1;
  localparam logic [15:0] OFF_COUNT = 16'd2;
  localparam logic [15:0] OFF_STAT  = 16'd3;
  localparam logic [15:0] OFF_PRESC = 16'd4;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int CTRL_W           = 3;

  // True when a bus offset (addr - base, modulo 2^16) lands on a register.
  function automatic logic off_in_range(input logic [15:0] off);
    return off <= OFF_PRESC;
  endfunction

endpackage

// File: rtl/io_prescaler.sv
// Clock divider: produces a one-cycle tick every div+1 enabled cycles.
module io_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == div);

  // Count while enabled, wrap on tick; clr (LOAD write) restarts the period.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr)       pcnt_d = '0;
    else if (en)   pcnt_d = tick ? '0 : pcnt_q + W'(1);
  end

  // Prescaler counter register.
  always_ff @(posedge clk) begin
    if (reset) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped programmable down-counter timer with level interrupt.
module io_timer
  import cpu_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = TIMER_BASE_ADDR,
  parameter int          CNT_W     = 16,
  parameter int          PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  input  logic        we,
  input  logic        re,
  output logic [15:0] rd_data,
  output logic        rd_oe,
  output logic        irq
);

  logic [CTRL_W-1:0]  ctrl_q,  ctrl_d;
  logic [CNT_W-1:0]   load_q,  load_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               exp_q,   exp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;

  logic [15:0] off;
  logic        in_range, wr, tick;

  assign off      = addr - BASE_ADDR;
  assign in_range = off_in_range(off);
  assign wr       = we && in_range;

  io_prescaler #(.W(PRESC_W)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .clr   (wr && (off == OFF_LOAD)),
    .div   (presc_q),
    .tick  (tick)
  );

  // Next state: STAT clear first so an expiry tick can re-set EXPIRED,
  // then tick effects, then CTRL/LOAD writes which override the tick.
  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    presc_d = presc_q;

    if (wr && off == OFF_STAT && wr_data[0]) exp_d = 1'b0;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        exp_d = 1'b1;
        if (ctrl_q[CTRL_AUTO_RELOAD]) count_d = load_q;
        else                          ctrl_d[CTRL_EN] = 1'b0;
      end
    end

    if (wr) begin
      case (off)
        OFF_CTRL:  ctrl_d  = wr_data[CTRL_W-1:0];
        OFF_LOAD: begin
          load_d  = wr_data[CNT_W-1:0];
          count_d = wr_data[CNT_W-1:0];
        end
        OFF_PRESC: presc_d = wr_data[PRESC_W-1:0];
        default: ;
      endcase
    end
  end

  // Register file and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      presc_q <= presc_d;
    end
  end

  assign irq   = exp_q & ctrl_q[CTRL_IRQ_EN];
  assign rd_oe = re && in_range;

  // Read mux: side-effect free, zero-extended, zero when not selected.
  always_comb begin
    rd_data = '0;
    if (rd_oe) begin
      case (off)
        OFF_CTRL:  rd_data = 16'(ctrl_q);
        OFF_LOAD:  rd_data = 16'(load_q);
        OFF_COUNT: rd_data = 16'(count_q);
        OFF_STAT:  rd_data = 16'(exp_q);
        OFF_PRESC: rd_data = 16'(presc_q);
        default:   rd_data = '0;
      endcase
    end
  end

endmodule
